// File: rtl/rice_block_sequencer.sv
// Sequencer for the Rice-decoding preprocessing datapath: validates the decode
// configuration, paces 32-bit words in, and frames one telemetry segment.
module rice_block_sequencer #(
  parameter int BLK_W     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic [5:0]       n,
  input  logic [5:0]       j,
  input  logic [5:0]       k,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             start,
  output logic             wren,
  output logic             datavalid,
  output logic             cdsdatavalid,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [5:0]       sample_idx,
  output logic [BLK_W-1:0] block_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ERR, S_START, S_RUN, S_DRAIN, S_FINISH
  } state_t;

  localparam logic [BLK_W-1:0] BLK_ONE   = BLK_W'(1);
  localparam logic [3:0]       DRAIN_END = 4'(DRAIN_CYC - 1);

  state_t           state, state_nx;
  logic [5:0]       n_q, j_q, k_q;
  logic [BLK_W-1:0] nb_q;
  logic [3:0]       drain_cnt;
  logic             abort_stop;
  logic             kill, cfg_ok, last_smp, last_blk, last_word;

  // abort is only honoured once the segment has been committed to the datapath
  assign kill = abort & (state inside {S_START, S_RUN, S_DRAIN});

  assign cfg_ok = (n_q != 6'd0) && (n_q <= 6'd32) &&
                  (j_q == 6'd8 || j_q == 6'd16 || j_q == 6'd32) &&
                  (k_q < n_q) && (nb_q != '0);

  assign last_smp  = (sample_idx == j_q - 6'd1);
  assign last_blk  = (block_idx == nb_q - BLK_ONE);
  assign last_word = wren & last_smp & last_blk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    word_ready = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_nx = S_CHECK;
      end
      S_CHECK:  state_nx = cfg_ok ? S_START : S_ERR;
      S_ERR:    state_nx = S_IDLE;
      S_START: begin
        start    = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        word_ready = ~abort;
        if (last_word) state_nx = S_DRAIN;
      end
      S_DRAIN:  if (drain_cnt == DRAIN_END) state_nx = S_FINISH;
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
    if (kill) state_nx = S_IDLE;
  end

  assign wren = word_valid & word_ready;
  // abort stop is issued from IDLE on the cycle after the abort
  assign stop = done | abort_stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      nb_q         <= '0;
      cfg_err      <= 1'b0;
      drain_cnt    <= '0;
      abort_stop   <= 1'b0;
      datavalid    <= 1'b0;
      cdsdatavalid <= 1'b0;
      sample_idx   <= '0;
      block_idx    <= '0;
    end else begin
      abort_stop   <= kill;
      datavalid    <= wren;
      cdsdatavalid <= wren & last_smp;
      drain_cnt    <= (state == S_DRAIN) ? drain_cnt + 4'd1 : 4'd0;

      if (state == S_IDLE && go) begin
        n_q     <= n;
        j_q     <= j;
        k_q     <= k;
        nb_q    <= num_blocks;
        cfg_err <= 1'b0;
      end
      if (state == S_ERR) cfg_err <= 1'b1;

      // counters start each segment at zero and block_idx saturates on the last block
      if (kill || state == S_START || (state == S_IDLE && go)) begin
        sample_idx <= '0;
        block_idx  <= '0;
      end else if (wren) begin
        if (last_smp) begin
          sample_idx <= '0;
          if (!last_blk) block_idx <= block_idx + BLK_ONE;
        end else begin
          sample_idx <= sample_idx + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rice_block_sequencer.sv
// Scoreboarded bench for rice_block_sequencer: a segment-level model predicts
// every output event with its cycle; a negedge monitor matches DUT events.
module tb_rice_block_sequencer;
  localparam int BLK_W     = 16;
  localparam int DRAIN_CYC = 2;

  logic             clk, reset, go, abort, word_valid;
  logic [5:0]       n, j, k;
  logic [BLK_W-1:0] num_blocks;
  logic             word_ready, start, wren, datavalid, cdsdatavalid;
  logic             stop, busy, done, cfg_err;
  logic [5:0]       sample_idx;
  logic [BLK_W-1:0] block_idx;

  rice_block_sequencer #(.BLK_W(BLK_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort), .n(n), .j(j), .k(k),
    .num_blocks(num_blocks), .word_valid(word_valid), .word_ready(word_ready),
    .start(start), .wren(wren), .datavalid(datavalid), .cdsdatavalid(cdsdatavalid),
    .stop(stop), .busy(busy), .done(done), .cfg_err(cfg_err),
    .sample_idx(sample_idx), .block_idx(block_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_DV = 0, K_WR = 1, K_ST = 2, K_SP = 3, K_ER = 4, K_EC = 5;
  typedef struct { int cyc; int kind; int a; int b; bit f; bit g; } ev_t;

  ev_t q[$];
  int  nvec = 0, nerr = 0;
  bit  mon_en = 1'b0;
  bit  err_m  = 1'b0;
  logic err_prev = 1'b0;

  function automatic string kname(input int kd);
    case (kd)
      K_DV: return "datavalid";
      K_WR: return "wren";
      K_ST: return "start";
      K_SP: return "stop";
      K_ER: return "cfg_err_set";
      default: return "cfg_err_clr";
    endcase
  endfunction

  task automatic push(input int c, input int kd, input int a, input int b, input bit f, input bit g);
    ev_t e;
    e.cyc = c; e.kind = kd; e.a = a; e.b = b; e.f = f; e.g = g;
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // f/g carry the event flags: cds for datavalid, done/busy for stop
  task automatic chk(input int kd, input bit f, input bit g);
    ev_t e;
    nvec++;
    if (q.size() == 0 || q[0].kind != kd || q[0].cyc != cyc) begin
      nerr++;
      if (q.size() == 0)
        $display("FAIL unexpected %s at cycle %0d, nothing pending", kname(kd), cyc);
      else
        $display("FAIL unexpected %s at cycle %0d, pending %s at cycle %0d",
                 kname(kd), cyc, kname(q[0].kind), q[0].cyc);
    end else begin
      e = q.pop_front();
      if (e.f != f || e.g != g || (e.a >= 0 && e.a != int'(sample_idx)) ||
          (e.b >= 0 && e.b != int'(block_idx))) begin
        nerr++;
        $display("FAIL %s fields at cycle %0d: got f=%0d g=%0d smp=%0d blk=%0d, expected f=%0d g=%0d smp=%0d blk=%0d",
                 kname(kd), cyc, f, g, sample_idx, block_idx, e.f, e.g, e.a, e.b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) err_prev = 1'b0;
    else if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        nvec++; nerr++;
        $display("FAIL missing %s: expected at cycle %0d, now %0d", kname(q[0].kind), q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (datavalid || cdsdatavalid) chk(K_DV, cdsdatavalid, 1'b0);
      if (wren)                      chk(K_WR, 1'b0, 1'b0);
      if (start)                     chk(K_ST, 1'b0, 1'b0);
      if (stop || done)              chk(K_SP, done, busy);
      if (cfg_err && !err_prev)      chk(K_ER, 1'b0, 1'b0);
      if (!cfg_err && err_prev)      chk(K_EC, 1'b0, 1'b0);
      err_prev = cfg_err;
    end
  end

  task automatic chk_zero(input string tag);
    cmp({tag, " word_ready"}, int'(word_ready), 0);
    cmp({tag, " wren"}, int'(wren), 0);
    cmp({tag, " start"}, int'(start), 0);
    cmp({tag, " datavalid"}, int'(datavalid), 0);
    cmp({tag, " cdsdatavalid"}, int'(cdsdatavalid), 0);
    cmp({tag, " stop"}, int'(stop), 0);
    cmp({tag, " busy"}, int'(busy), 0);
    cmp({tag, " done"}, int'(done), 0);
    cmp({tag, " cfg_err"}, int'(cfg_err), 0);
    cmp({tag, " sample_idx"}, int'(sample_idx), 0);
    cmp({tag, " block_idx"}, int'(block_idx), 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // vmode: 0 always valid, 1 alternating, 2 random; abort_at/rst_at: 1-based word number
  task automatic run_seg(input int nn, input int jj, input int kk, input int nb,
                         input int vmode, input int abort_at, input int rst_at);
    bit legal, v, ended;
    int g, acc, total, c, lastc;
    legal = nn >= 1 && nn <= 32 && (jj == 8 || jj == 16 || jj == 32) && kk < nn && nb >= 1;
    tick();
    g = cyc;
    go = 1'b1; n = 6'(nn); j = 6'(jj); k = 6'(kk); num_blocks = BLK_W'(nb);
    if (err_m) push(g + 1, K_EC, -1, -1, 1'b0, 1'b0);
    err_m = 1'b0;
    if (legal) push(g + 2, K_ST, 0, 0, 1'b0, 1'b0);
    else begin
      push(g + 3, K_ER, -1, -1, 1'b0, 1'b0);
      err_m = 1'b1;
    end
    tick();
    go = 1'b0;
    // scramble config ports: latched values must not follow them
    n = 6'($urandom); j = 6'($urandom); k = 6'($urandom); num_blocks = BLK_W'($urandom);
    if (!legal) begin
      repeat (4) tick();
      return;
    end
    tick(); tick();
    total = jj * nb; acc = 0; lastc = -1; ended = 1'b0;
    for (int t = 0; t < 4000 && !ended; t++) begin
      c = cyc;
      if (rst_at > 0 && acc == rst_at) begin
        reset = 1'b0;
        q.delete();
        #1;
        chk_zero("async reset");
        tick();
        reset = 1'b1; err_m = 1'b0; word_valid = 1'b0;
        tick();
        cmp("post-reset busy", int'(busy), 0);
        cmp("post-reset cfg_err", int'(cfg_err), 0);
        return;
      end
      if (abort_at > 0 && acc == abort_at - 1) begin
        word_valid = 1'b1; abort = 1'b1;
        push(c + 1, K_SP, 0, 0, 1'b0, 1'b0);
        tick();
        abort = 1'b0; word_valid = 1'b0;
        ended = 1'b1;
      end else begin
        case (vmode)
          0: v = 1'b1;
          1: v = (t % 2 == 0);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        word_valid = v;
        if (v) begin
          push(c, K_WR, acc % jj, acc / jj, 1'b0, 1'b0);
          acc++;
          push(c + 1, K_DV, -1, -1, (acc % jj) == 0, 1'b0);
          if (acc == total) begin
            lastc = c;
            push(c + DRAIN_CYC + 1, K_SP, -1, -1, 1'b1, 1'b1);
            ended = 1'b1;
          end
        end
        tick();
      end
    end
    if (!ended) begin
      nvec++; nerr++;
      $display("FAIL segment timeout: %0d of %0d words accepted", acc, total);
    end
    if (lastc >= 0) begin
      while (cyc < lastc + DRAIN_CYC + 2) begin
        word_valid = 1'($urandom);
        tick();
      end
      word_valid = 1'b0;
      cmp("busy after finish", int'(busy), 0);
    end
    for (int t = 0; t < 20 && q.size() > 0; t++) tick();
    if (q.size() > 0) begin
      nvec++; nerr++;
      $display("FAIL scoreboard not drained: %0d events left", q.size());
      q.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int nn, jj, kk, nb, ab;
    reset = 1'b0; go = 1'b0; abort = 1'b0; word_valid = 1'b0;
    n = '0; j = '0; k = '0; num_blocks = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    mon_en = 1'b1;

    run_seg(16, 8, 3, 2, 0, 0, 0);
    run_seg(16, 12, 3, 2, 0, 0, 0);
    cmp("cfg_err after bad j", int'(cfg_err), 1);
    run_seg(16, 8, 3, 1, 0, 0, 0);
    cmp("cfg_err cleared", int'(cfg_err), 0);
    run_seg(16, 16, 16, 2, 0, 0, 0);
    run_seg(32, 32, 31, 1, 0, 0, 0);
    run_seg(16, 8, 3, 3, 1, 0, 0);
    run_seg(16, 8, 3, 2, 0, 5, 0);
    run_seg(0, 8, 0, 1, 0, 0, 0);
    run_seg(33, 8, 3, 1, 0, 0, 0);
    run_seg(16, 8, 3, 0, 0, 0, 0);
    run_seg(1, 8, 0, 1, 2, 0, 0);
    run_seg(12, 16, 5, 2, 2, 32, 0);

    for (int s = 0; s < 25; s++) begin
      nn = $urandom_range(1, 32);
      kk = $urandom_range(0, nn - 1);
      case ($urandom_range(0, 2))
        0: jj = 8;
        1: jj = 16;
        default: jj = 32;
      endcase
      nb = $urandom_range(1, 3);
      case ($urandom_range(0, 9))
        0: jj = $urandom_range(0, 40);
        1: kk = $urandom_range(nn, 63);
        2: nb = 0;
        default: ;
      endcase
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, jj * nb + 1) : 0;
      run_seg(nn, jj, kk, nb, $urandom_range(0, 2), ab, 0);
    end

    run_seg(16, 8, 3, 3, 0, 0, 10);
    run_seg(16, 8, 3, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
